// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory-stage bus master: funct3 codes, FSM states
// and default timing constants.
package memory_access_unit_pkg;

    localparam int unsigned CLOCK_PERIOD = 10;
    localparam int unsigned MAU_TIMEOUT  = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MAU_IDLE,
        MAU_ACCESS,
        MAU_DONE
    } mau_state_t;

endpackage

// File: rtl/memory_access_unit_load_extender.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it
// according to the load funct3; LW passes the word through.
module memory_access_unit_load_extender
    import memory_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    always_comb begin
        // Halfwords are aligned, so the same byte shift selects the right half.
        w_shifted = i_rdata >> {i_byte_off, 3'b000};
        unique case (i_funct3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_data = {24'h0, w_shifted[7:0]};
            F3_LHU:  o_data = {16'h0, w_shifted[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage data-bus master: single-outstanding req/ack access with stall,
// store lane steering, load extension and timeout abort.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MAU_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Mem_Read_M,
    input  logic        Mem_Write_M,
    input  logic [2:0]  Funct3_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] Write_Data_M,
    output logic [31:0] Data_Out_Ext_M,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        Access_Err_M,
    output logic        Bus_Err_M,
    output logic        Bus_Req,
    output logic        Bus_We,
    output logic [31:0] Bus_Addr,
    output logic [3:0]  Bus_Be,
    output logic [31:0] Bus_Wdata,
    input  logic        Bus_Ack,
    input  logic [31:0] Bus_Rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mau_state_t        r_state;
    mau_state_t        w_state_next;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [1:0]        r_byte_off;
    logic [2:0]        r_funct3;
    logic [CntW-1:0]   r_cnt;
    logic [31:0]       r_data;
    logic              r_err;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_valid_req;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ext;

    // A simultaneous read and write is treated as a read.
    assign w_is_load  = Mem_Read_M;
    assign w_is_store = Mem_Write_M & ~Mem_Read_M;

    always_comb begin
        Misaligned_M = 1'b0;
        Access_Err_M = 1'b0;
        if (w_is_load) begin
            unique case (Funct3_M)
                F3_LB, F3_LBU: Misaligned_M = 1'b0;
                F3_LH, F3_LHU: Misaligned_M = ALU_Out_M[0];
                F3_LW:         Misaligned_M = |ALU_Out_M[1:0];
                default:       Access_Err_M = 1'b1;
            endcase
        end else if (w_is_store) begin
            unique case (Funct3_M)
                F3_SB:   Misaligned_M = 1'b0;
                F3_SH:   Misaligned_M = ALU_Out_M[0];
                F3_SW:   Misaligned_M = |ALU_Out_M[1:0];
                default: Access_Err_M = 1'b1;
            endcase
        end
    end

    assign w_valid_req = (w_is_load | w_is_store) & ~Misaligned_M & ~Access_Err_M;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = Write_Data_M;
        if (w_is_store) begin
            unique case (Funct3_M)
                F3_SB: begin
                    w_be    = 4'b0001 << ALU_Out_M[1:0];
                    w_wdata = {4{Write_Data_M[7:0]}};
                end
                F3_SH: begin
                    w_be    = 4'b0011 << {ALU_Out_M[1], 1'b0};
                    w_wdata = {2{Write_Data_M[15:0]}};
                end
                default: ;
            endcase
        end
    end

    memory_access_unit_load_extender u_load_extender (
        .i_rdata    (Bus_Rdata),
        .i_byte_off (r_byte_off),
        .i_funct3   (r_funct3),
        .o_data     (w_ext)
    );

    assign w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) & ~Bus_Ack;

    always_comb begin
        w_state_next = r_state;
        Stall_M      = 1'b0;
        unique case (r_state)
            MAU_IDLE: begin
                if (w_valid_req) begin
                    w_state_next = MAU_ACCESS;
                    Stall_M      = 1'b1;
                end
            end
            MAU_ACCESS: begin
                Stall_M = 1'b1;
                if (Bus_Ack || w_timeout) begin
                    w_state_next = MAU_DONE;
                end
            end
            MAU_DONE: w_state_next = MAU_IDLE;
            default:  w_state_next = MAU_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= MAU_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_byte_off <= '0;
            r_funct3   <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Result and error live for exactly the DONE cycle.
            r_data  <= '0;
            r_err   <= 1'b0;
            unique case (r_state)
                MAU_IDLE: begin
                    if (w_valid_req) begin
                        r_req      <= 1'b1;
                        r_we       <= w_is_store;
                        r_addr     <= {ALU_Out_M[31:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_byte_off <= ALU_Out_M[1:0];
                        r_funct3   <= Funct3_M;
                        r_cnt      <= '0;
                    end
                end
                MAU_ACCESS: begin
                    if (Bus_Ack) begin
                        r_req  <= 1'b0;
                        r_data <= r_we ? 32'h0 : w_ext;
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Bus_Req        = r_req;
    assign Bus_We         = r_we;
    assign Bus_Addr       = r_addr;
    assign Bus_Be         = r_be;
    assign Bus_Wdata      = r_wdata;
    assign Data_Out_Ext_M = r_data;
    assign Bus_Err_M      = r_err;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed plus randomized bench for memory_access_unit against a plain
// arithmetic reference model of lanes, extension, errors and latency.
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    localparam int TO = 16;

    logic        CLK;
    logic        RST;
    logic        Mem_Read_M;
    logic        Mem_Write_M;
    logic [2:0]  Funct3_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] Write_Data_M;
    logic [31:0] Data_Out_Ext_M;
    logic        Stall_M;
    logic        Misaligned_M;
    logic        Access_Err_M;
    logic        Bus_Err_M;
    logic        Bus_Req;
    logic        Bus_We;
    logic [31:0] Bus_Addr;
    logic [3:0]  Bus_Be;
    logic [31:0] Bus_Wdata;
    logic        Bus_Ack;
    logic [31:0] Bus_Rdata;

    int n_checks = 0;
    int n_errors = 0;

    memory_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Mem_Read_M     (Mem_Read_M),
        .Mem_Write_M    (Mem_Write_M),
        .Funct3_M       (Funct3_M),
        .ALU_Out_M      (ALU_Out_M),
        .Write_Data_M   (Write_Data_M),
        .Data_Out_Ext_M (Data_Out_Ext_M),
        .Stall_M        (Stall_M),
        .Misaligned_M   (Misaligned_M),
        .Access_Err_M   (Access_Err_M),
        .Bus_Err_M      (Bus_Err_M),
        .Bus_Req        (Bus_Req),
        .Bus_We         (Bus_We),
        .Bus_Addr       (Bus_Addr),
        .Bus_Be         (Bus_Be),
        .Bus_Wdata      (Bus_Wdata),
        .Bus_Ack        (Bus_Ack),
        .Bus_Rdata      (Bus_Rdata)
    );

    initial CLK = 1'b0;
    always #(CLOCK_PERIOD / 2) CLK = ~CLK;

    initial begin
        #(CLOCK_PERIOD * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rdat, input int off,
                                               input logic [2:0] f3);
        int unsigned v;
        int s;
        v = rdat >> (8 * off);
        case (f3)
            3'd0: begin
                v = v % 256;
                s = (v >= 128) ? int'(v) - 256 : int'(v);
                return 32'(s);
            end
            3'd1: begin
                v = v % 65536;
                s = (v >= 32768) ? int'(v) - 65536 : int'(v);
                return 32'(s);
            end
            3'd4:    return 32'(v % 256);
            3'd5:    return 32'(v % 65536);
            default: return rdat;
        endcase
    endfunction

    // ack_wait: number of ACCESS cycles without ack before the ack cycle; <0 means never.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_wait,
                          output int stalls, output logic [31:0] data);
        logic is_rd, is_wr, err, mis, valid, tout, done;
        int size, off;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        is_rd = rd;
        is_wr = wr && !rd;
        err   = is_rd ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) :
                is_wr ? !(f3 inside {3'd0, 3'd1, 3'd2}) : 1'b0;
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        mis   = (is_rd || is_wr) && !err && (off % size != 0);
        valid = (is_rd || is_wr) && !err && !mis;
        ebe   = is_wr ? 4'(((1 << size) - 1) << off) : 4'hF;
        ewd   = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        eld   = model_load(rdat, off, f3);
        tout  = ack_wait < 0;
        stalls = 0;
        data   = '0;

        @(negedge CLK);
        Mem_Read_M   = rd;
        Mem_Write_M  = wr;
        Funct3_M     = f3;
        ALU_Out_M    = addr;
        Write_Data_M = wd;
        Bus_Ack      = 1'b0;
        #1;
        check("misaligned", 32'(Misaligned_M), 32'(mis));
        check("access_err", 32'(Access_Err_M), 32'(err));
        check("stall_accept", 32'(Stall_M), 32'(valid));

        if (!valid) begin
            @(negedge CLK);
            #1;
            check("err_no_req", 32'(Bus_Req), 32'd0);
            check("err_no_stall", 32'(Stall_M), 32'd0);
            check("err_no_data", Data_Out_Ext_M, 32'd0);
        end else begin
            done   = 1'b0;
            stalls = 1;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge CLK);
                Bus_Ack   = (c == ack_wait);
                Bus_Rdata = (c == ack_wait) ? rdat : $urandom();
                #1;
                if (Stall_M) begin
                    stalls++;
                    if (c == 0) begin
                        check("req_high", 32'(Bus_Req), 32'd1);
                        check("bus_we", 32'(Bus_We), 32'(is_wr));
                        check("bus_addr", Bus_Addr, {addr[31:2], 2'b00});
                        check("bus_be", 32'(Bus_Be), 32'(ebe));
                        if (is_wr) check("bus_wdata", Bus_Wdata, ewd);
                    end
                end else begin
                    done = 1'b1;
                    check("stall_cycles", 32'(stalls), tout ? 32'(TO + 1) : 32'(ack_wait + 2));
                    check("done_req_low", 32'(Bus_Req), 32'd0);
                    check("done_bus_err", 32'(Bus_Err_M), 32'(tout));
                    check("done_addr", Bus_Addr, {addr[31:2], 2'b00});
                    if (is_rd) check("done_data", Data_Out_Ext_M, tout ? 32'd0 : eld);
                    data = Data_Out_Ext_M;
                end
            end
            check("done_reached", 32'(done), 32'd1);
            @(negedge CLK);
            Mem_Read_M  = 1'b0;
            Mem_Write_M = 1'b0;
            Bus_Ack     = 1'b0;
            #1;
            check("err_clear", 32'(Bus_Err_M), 32'd0);
            check("data_clear", Data_Out_Ext_M, 32'd0);
        end
        Mem_Read_M  = 1'b0;
        Mem_Write_M = 1'b0;
    endtask

    initial begin
        int st;
        logic [31:0] d;
        logic [2:0] legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        RST          = 1'b1;
        Mem_Read_M   = 1'b0;
        Mem_Write_M  = 1'b0;
        Funct3_M     = 3'd0;
        ALU_Out_M    = '0;
        Write_Data_M = '0;
        Bus_Ack      = 1'b0;
        Bus_Rdata    = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_req", 32'(Bus_Req), 32'd0);
        check("rst_we", 32'(Bus_We), 32'd0);
        check("rst_be", 32'(Bus_Be), 32'd0);
        check("rst_addr", Bus_Addr, 32'd0);
        check("rst_wdata", Bus_Wdata, 32'd0);
        check("rst_data", Data_Out_Ext_M, 32'd0);
        check("rst_bus_err", 32'(Bus_Err_M), 32'd0);
        check("rst_stall", 32'(Stall_M), 32'd0);

        // LB at 0x1003, first-cycle ack.
        run_op(1, 0, F3_LB, 32'h1003, 32'h0, 32'h80FF_1234, 0, st, d);
        check("lb_stalls", 32'(st), 32'd2);
        check("lb_value", d, 32'hFFFF_FF80);
        // LHU at 0x2002, three wait cycles.
        run_op(1, 0, F3_LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 3, st, d);
        check("lhu_stalls", 32'(st), 32'd5);
        check("lhu_value", d, 32'h0000_BEEF);
        // Stores.
        run_op(0, 1, F3_SB, 32'h3001, 32'h1234_56AB, 32'h0, 1, st, d);
        run_op(0, 1, F3_SH, 32'h3002, 32'h1234_56AB, 32'h0, 0, st, d);
        run_op(0, 1, F3_SW, 32'h3004, 32'hCAFE_F00D, 32'h0, 2, st, d);
        // Errors.
        run_op(1, 0, F3_LW, 32'h4002, 32'h0, 32'h0, 0, st, d);
        run_op(1, 0, 3'b011, 32'h4000, 32'h0, 32'h0, 0, st, d);
        run_op(0, 1, 3'b100, 32'h4000, 32'h0, 32'h0, 0, st, d);
        // Timeout followed by a normal LW.
        run_op(1, 0, F3_LW, 32'h5000, 32'h0, 32'h0, -1, st, d);
        check("timeout_stalls", 32'(st), 32'd17);
        run_op(1, 0, F3_LW, 32'h5004, 32'h0, 32'h1357_9BDF, 0, st, d);
        check("post_timeout_lw", d, 32'h1357_9BDF);

        // Reset during the second ACCESS cycle, then a late ack.
        @(negedge CLK);
        Mem_Read_M = 1'b1;
        Funct3_M   = F3_LW;
        ALU_Out_M  = 32'h6000;
        Bus_Ack    = 1'b0;
        #1;
        check("rstacc_accept", 32'(Stall_M), 32'd1);
        @(negedge CLK);
        #1;
        check("rstacc_req1", 32'(Bus_Req), 32'd1);
        @(negedge CLK);
        RST        = 1'b1;
        Mem_Read_M = 1'b0;
        #1;
        check("rstacc_req2", 32'(Bus_Req), 32'd1);
        @(negedge CLK);
        RST       = 1'b0;
        Bus_Ack   = 1'b1;
        Bus_Rdata = 32'hDEAD_BEEF;
        #1;
        check("rstacc_req_low", 32'(Bus_Req), 32'd0);
        check("rstacc_stall", 32'(Stall_M), 32'd0);
        check("rstacc_addr", Bus_Addr, 32'd0);
        check("rstacc_be", 32'(Bus_Be), 32'd0);
        @(negedge CLK);
        Bus_Ack = 1'b0;
        #1;
        check("late_ack_req", 32'(Bus_Req), 32'd0);
        check("late_ack_data", Data_Out_Ext_M, 32'd0);
        check("late_ack_err", 32'(Bus_Err_M), 32'd0);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic rd, wr;
            logic [2:0] f3;
            kind = int'($urandom_range(0, 3));
            rd   = (kind != 1);
            wr   = (kind == 1) || (kind == 2);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (rd) f3 = legal_ld[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            run_op(rd, wr, f3, $urandom(), $urandom(), $urandom(),
                   int'($urandom_range(0, 4)), st, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
